// File: rtl/count_snapshot_fifo.sv
// rtl/count_snapshot_fifo.sv - FWFT FIFO of captured count values with sticky overflow.
// Optional per-entry delta from the previous accepted capture under SNAPSHOT_DELTA_EN.
module count_snapshot_fifo #(
    parameter int Size  = 5,
    parameter int Depth = 4,
    parameter int AddrW = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Size-1:0]  count,
    input  logic             capture,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [Size-1:0]  out_count,
`ifdef SNAPSHOT_DELTA_EN
    output logic [Size-1:0]  out_delta,
`endif
    output logic [AddrW:0]   level,
    output logic             overflow,
    input  logic             clear_overflow
);

    logic [Size-1:0]  count_mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             full, pop, push, drop;

    assign full = (level_q == (AddrW+1)'(Depth));
    assign pop  = (level_q != '0) && out_ready;
    // A full FIFO still accepts a capture when the head leaves on the same edge.
    assign push = capture && (!full || pop);
    assign drop = capture && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + AddrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AddrW'(1);
        if (push && !pop)      level_d = level_q + (AddrW+1)'(1);
        else if (pop && !push) level_d = level_q - (AddrW+1)'(1);
        if (clear_overflow) overflow_d = 1'b0;
        if (drop)           overflow_d = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < Depth; i++) count_mem_q[i] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            if (push) count_mem_q[wr_ptr_q] <= count;
        end
    end

`ifdef SNAPSHOT_DELTA_EN
    logic [Size-1:0] delta_mem_q [Depth];
    logic [Size-1:0] prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            for (int i = 0; i < Depth; i++) delta_mem_q[i] <= '0;
        end else if (push) begin
            prev_q                <= count;
            delta_mem_q[wr_ptr_q] <= count - prev_q;
        end
    end

    assign out_delta = delta_mem_q[rd_ptr_q];
`endif

    assign out_valid = (level_q != '0);
    assign out_count = count_mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_count_snapshot_fifo.sv
// tb/tb_count_snapshot_fifo.sv - directed self-checking bench for count_snapshot_fifo.
module tb_count_snapshot_fifo;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] count;
    logic       capture;
    logic       out_ready;
    logic       out_valid;
    logic [4:0] out_count;
`ifdef SNAPSHOT_DELTA_EN
    logic [4:0] out_delta;
`endif
    logic [2:0] level;
    logic       overflow;
    logic       clear_overflow;

    int errors = 0;
    int checks = 0;

    count_snapshot_fifo #(.Size(5), .Depth(4), .AddrW(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .count          (count),
        .capture        (capture),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_count      (out_count),
`ifdef SNAPSHOT_DELTA_EN
        .out_delta      (out_delta),
`endif
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_vals(input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] c, input logic [4:0] d);
        logic [4:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            count = v[i]; capture = 1'b1;
            tick();
        end
        capture = 1'b0;
    endtask

    task automatic test_reset();
        count = '0; capture = 0; out_ready = 0; clear_overflow = 0;
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 || out_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b level=%0d ovf=%b count=%0d required 0/0/0/0",
                     out_valid, level, overflow, out_count);
        end
    endtask

    task automatic test_empty_capture();
        count = 5'd3; capture = 1'b1;
        tick();
        capture = 1'b0; count = 5'd9;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 5'd3 || level !== 3'd1) begin
            errors++;
            $display("FAIL empty_capture: valid=%b count=%0d level=%0d required 1/3/1",
                     out_valid, out_count, level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL empty_pop: valid=%b level=%0d required 0/0", out_valid, level);
        end
    endtask

    task automatic test_fill_drop();
        push_vals(5'd1, 5'd2, 5'd3, 5'd4);
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_level: level=%0d ovf=%b required 4/0", level, overflow);
        end
        count = 5'd5; capture = 1'b1;
        tick();
        capture = 1'b0;
        checks++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop: level=%0d ovf=%b required 4/1", level, overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_count !== 5'(i)) begin
                errors++;
                $display("FAIL drain_order[%0d]: valid=%b count=%0d required 1/%0d",
                         i, out_valid, out_count, i);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drained_sticky: valid=%b ovf=%b required 0/1", out_valid, overflow);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd0) begin
            errors++;
            $display("FAIL ready_when_empty: level=%0d required 0", level);
        end
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_overflow: ovf=%b required 0", overflow);
        end
    endtask

    task automatic test_full_push_pop();
        push_vals(5'd1, 5'd2, 5'd3, 5'd4);
        count = 5'd5; capture = 1'b1; out_ready = 1'b1;
        tick();
        capture = 1'b0; out_ready = 1'b0;
        checks++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: level=%0d ovf=%b required 4/0", level, overflow);
        end
        for (int i = 2; i <= 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_count !== 5'(i)) begin
                errors++;
                $display("FAIL full_pp_order[%0d]: valid=%b count=%0d required 1/%0d",
                         i, out_valid, out_count, i);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL full_pp_empty: valid=%b level=%0d required 0/0", out_valid, level);
        end
    endtask

`ifdef SNAPSHOT_DELTA_EN
    task automatic test_delta();
        logic [4:0] exp_c [4];
        logic [4:0] exp_d [4];
        do_reset();
        push_vals(5'd30, 5'd2, 5'd7, 5'd9);
        checks++;
        if (out_count !== 5'd30 || out_delta !== 5'd30) begin
            errors++;
            $display("FAIL delta_first: count=%0d delta=%0d required 30/30", out_count, out_delta);
        end
        count = 5'd20; capture = 1'b1;
        tick();
        capture = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0; count = 5'd11; capture = 1'b1;
        tick();
        capture = 1'b0;
        exp_c[0] = 5'd2;  exp_d[0] = 5'd4;
        exp_c[1] = 5'd7;  exp_d[1] = 5'd5;
        exp_c[2] = 5'd9;  exp_d[2] = 5'd2;
        exp_c[3] = 5'd11; exp_d[3] = 5'd2;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_count !== exp_c[i] || out_delta !== exp_d[i]) begin
                errors++;
                $display("FAIL delta_seq[%0d]: count=%0d delta=%0d required %0d/%0d",
                         i, out_count, out_delta, exp_c[i], exp_d[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        push_vals(5'd6, 5'd7, 5'd8, 5'd9);
        count = 5'd10; capture = 1'b1;
        tick();
        capture = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (level !== 3'd3 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL pre_async_reset: level=%0d ovf=%b required 3/1", level, overflow);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b level=%0d ovf=%b required 0/0/0",
                     out_valid, level, overflow);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_clear_vs_set();
        push_vals(5'd1, 5'd2, 5'd3, 5'd4);
        count = 5'd5; capture = 1'b1;
        tick();
        clear_overflow = 1'b1;
        tick();
        capture = 1'b0;
        checks++;
        if (overflow !== 1'b1 || level !== 3'd4) begin
            errors++;
            $display("FAIL clear_vs_set: ovf=%b level=%0d required 1/4", overflow, level);
        end
        tick();
        clear_overflow = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: ovf=%b required 0", overflow);
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_empty_capture();
        test_fill_drop();
        test_full_push_pop();
`ifdef SNAPSHOT_DELTA_EN
        test_delta();
`endif
        test_async_reset();
        test_clear_vs_set();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
